// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of ALU and load write-backs onto one register file write port
module regfile_wb_arbiter #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [AW-1:0]  a_addr,
    input  logic [DW-1:0]  a_data,
    input  logic           l_valid,
    output logic           l_ready,
    input  logic [AW-1:0]  l_addr,
    input  logic [DW-1:0]  l_data,
    input  logic [OPW-1:0] l_opcode,
    input  logic [AW-1:0]  rs,
    input  logic [AW-1:0]  rt,
    output logic           rs_pending,
    output logic           rt_pending,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [DW-1:0]  wr_data
);
    localparam logic [OPW-1:0] OP_LBU = OPW'(6'h24);
    localparam logic [OPW-1:0] OP_LHU = OPW'(6'h25);

    logic          a_full_q, a_full_d, l_full_q, l_full_d;
    logic [AW-1:0] a_addr_q, a_addr_d, l_addr_q, l_addr_d;
    logic [DW-1:0] a_data_q, a_data_d, l_data_q, l_data_d;
    logic          ptr_q, ptr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          a_acc, l_acc, a_gnt, l_gnt;
    logic [DW-1:0] l_ext;

    assign a_ready    = !a_full_q;
    assign l_ready    = !l_full_q;
    assign a_acc      = a_valid && a_ready;
    assign l_acc      = l_valid && l_ready;
    // ptr_q = 0 favours A, 1 favours L; it only matters when both buffers compete
    assign a_gnt      = a_full_q && (!l_full_q || !ptr_q);
    assign l_gnt      = l_full_q && (!a_full_q || ptr_q);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rs_pending = (rs != '0) && ((a_full_q && a_addr_q == rs) || (l_full_q && l_addr_q == rs) || (wr_en_q && wr_addr_q == rs));
    assign rt_pending = (rt != '0) && ((a_full_q && a_addr_q == rt) || (l_full_q && l_addr_q == rt) || (wr_en_q && wr_addr_q == rt));

    // Zero-extend byte/halfword loads before they enter the load buffer
    always_comb begin
        l_ext = (l_opcode == OP_LBU) ? {{(DW-8){1'b0}}, l_data[7:0]} :
                (l_opcode == OP_LHU) ? {{(DW-16){1'b0}}, l_data[15:0]} : l_data;
    end

    // Buffer fill/drain, pointer flip on contention, and write-port next state
    always_comb begin
        a_full_d  = a_acc ? 1'b1 : (a_gnt ? 1'b0 : a_full_q);
        l_full_d  = l_acc ? 1'b1 : (l_gnt ? 1'b0 : l_full_q);
        a_addr_d  = a_acc ? a_addr : a_addr_q;
        a_data_d  = a_acc ? a_data : a_data_q;
        l_addr_d  = l_acc ? l_addr : l_addr_q;
        l_data_d  = l_acc ? l_ext : l_data_q;
        ptr_d     = (a_full_q && l_full_q) ? !ptr_q : ptr_q;
        wr_en_d   = a_gnt ? (a_addr_q != '0) : (l_gnt ? (l_addr_q != '0) : 1'b0);
        wr_addr_d = a_gnt ? a_addr_q : (l_gnt ? l_addr_q : wr_addr_q);
        wr_data_d = a_gnt ? a_data_q : (l_gnt ? l_data_q : wr_data_q);
    end

    // State registers; reset discards any buffered requests
    always_ff @(posedge clk) begin
        if (rst) begin
            a_full_q  <= 1'b0;
            l_full_q  <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            l_addr_q  <= '0;
            l_data_q  <= '0;
            ptr_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            a_full_q  <= a_full_d;
            l_full_q  <= l_full_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            l_addr_q  <= l_addr_d;
            l_data_q  <= l_data_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: port A (ALU results) and port L (load results).
- Each port has a one-entry holding buffer and a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port (wr_en/wr_addr/wr_data) that feeds the register file.
- Load data is zero-extended per opcode (LBU/LHU).
- Supplies pending-write hazard flags for the decode stage's rs/rt reads.

Parameters:
- DW, 32, data width
- AW, 5, register address width (2**AW registers)
- OPW, 6, opcode width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  ALU write-back request
- a_ready  out  1  ALU holding buffer empty
- a_addr  in  AW  ALU destination register
- a_data  in  DW  ALU result
- l_valid  in  1  load write-back request
- l_ready  out  1  load holding buffer empty
- l_addr  in  AW  load destination register
- l_data  in  DW  raw memory word
- l_opcode  in  OPW  load opcode
- rs  in  AW  decode read address 1
- rt  in  AW  decode read address 2
- rs_pending  out  1  rs has an outstanding write
- rt_pending  out  1  rt has an outstanding write
- wr_en  out  1  register file write strobe
- wr_addr  out  AW  register file write address
- wr_data  out  DW  register file write data

Behaviour:
- Reset:
  - both holding buffers empty, so a_ready=l_ready=1
  - wr_en=0, wr_addr=0, wr_data=0
  - round-robin pointer = A (A has priority first)
  - rs_pending=rt_pending=0
- Accept:
  - port X is accepted on an edge where X_valid && X_ready.
  - addr and data are captured into buffer X.
  - The load buffer stores data already extended:
    - opcode 6'h24 (LBU): {24'b0, l_data[7:0]}
    - opcode 6'h25 (LHU): {16'b0, l_data[15:0]}
    - any other opcode: l_data unchanged
  - X_ready is combinational: X_ready = !buffer_full_X. A buffer cannot be refilled in the cycle it drains; its ready rises the cycle after the drain.
- Arbitration (every cycle, on buffer state only):
  - Neither buffer full: no grant; wr_en=0 at the next edge.
  - Exactly one full: grant that buffer.
  - Both full: grant the pointer side, then flip the pointer to the other side.
  - Pointer changes only when both buffers compete.
- Granted buffer:
  - empties at the edge.
  - At the same edge the output registers load wr_addr/wr_data from it.
  - wr_en = 1 unless the address is 0. Writes to r0 are drained silently: wr_en=0, and wr_addr/wr_data still update.
- Latency:
  - accept at edge N; buffer is full during cycle N..N+1.
  - uncontested: wr_en is visible after edge N+1, i.e. one cycle.
  - contested loser: two cycles.
- Throughput:
  - one write per cycle overall.
  - each port sustains one accept per two cycles.
- Hazard flags (combinational):
  - rs_pending = (rs!=0) && (rs matches a full buffer's addr, or wr_en && wr_addr==rs).
  - rt_pending is the same with rt.
  - The wr stage counts because the register file updates on the following edge.
- Simultaneous events:
  - An accept into one buffer and a drain of the other on the same edge are both legal.
  - Both ports may target the same register. Write order is arbitration order, which software must not rely on. The hazard flag covers both buffers.
- Reset mid-operation:
  - Buffered requests are discarded; no wr_en is issued for them.
  - Outputs return to their reset values at that edge.
  - An accept and a reset on the same edge: reset wins.
- X_valid while !X_ready: the request is not taken. The requester holds its inputs stable until accepted.

Test Plan:
- Reset, then idle: a_ready=l_ready=1, wr_en=0, and both pending flags are 0 for 10 cycles.
- ALU write r14=32'hDEADBEEF at edge N → wr_en=1, wr_addr=14, wr_data=DEADBEEF in cycle N+1 only. rs=14 gives rs_pending=1 during cycles N..N+1 and 0 after.
- Load into r3 with l_data=32'd5550123 (0x0054B02B):
  - opcode 6'h24 → wr_data=0x0000002B
  - opcode 6'h25 → wr_data=0x0000B02B
  - opcode 6'h23 → wr_data=0x0054B02B
- Both ports valid at the same edge after reset (A: r5=1, L: r6=2) → cycle+1 writes r5=1, cycle+2 writes r6=2. Repeat the pair: L is written first, then A, confirming alternation.
- ALU write to r0 with data 32'hFFFFFFFF → a_ready drops for one cycle, wr_en stays 0, rs=0 gives rs_pending=0.
- Both buffers full, rst=1 for one edge → no wr_en in any following cycle, a_ready=l_ready=1, and the next contested pair is granted to A first.
